// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 convolution window datapath.
package conv_pkg;
  localparam int unsigned K          = 3;
  localparam int unsigned DATA_W_DEF = 9;

  // Window element indices: row-major, top-left first, bottom-right newest.
  localparam int unsigned W_TL = 0;
  localparam int unsigned W_TM = 1;
  localparam int unsigned W_TR = 2;
  localparam int unsigned W_ML = 3;
  localparam int unsigned W_MM = 4;
  localparam int unsigned W_MR = 5;
  localparam int unsigned W_BL = 6;
  localparam int unsigned W_BM = 7;
  localparam int unsigned W_BR = 8;
endpackage

// File: rtl/row_delay.sv
// DEPTH-deep, DATA_W-wide delay line advancing only when en is high.
module row_delay #(
  parameter int unsigned DATA_W = 9,
  parameter int unsigned DEPTH  = 226
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  logic [DEPTH*DATA_W-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst)
      sr <= '0;
    else if (en)
      sr <= {sr[(DEPTH-1)*DATA_W-1:0], din};
  end

  assign dout = sr[DEPTH*DATA_W-1 -: DATA_W];
endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator: raster pixels in, one window per valid
// output position out, with valid/ready flow control on both sides.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned IMG_W  = 226,
  parameter int unsigned IMG_H  = 226,
  parameter int unsigned STRIDE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [K*K*DATA_W-1:0] win,
  output logic                  out_last
);
  localparam int unsigned COL_W    = $clog2(IMG_W);
  localparam int unsigned ROW_W    = $clog2(IMG_H);
  localparam int unsigned LAST_ROW = 2 + ((IMG_H - 3) / STRIDE) * STRIDE;
  localparam int unsigned LAST_COL = 2 + ((IMG_W - 3) / STRIDE) * STRIDE;

  logic [COL_W-1:0]       col;
  logic [ROW_W-1:0]       row;
  logic                   accept;
  logic                   stride_ok;
  logic                   emit_pos;
  logic                   last_pos;
  logic [DATA_W-1:0]      rd0_out;
  logic [DATA_W-1:0]      rd1_out;
  logic [DATA_W-1:0]      col_l   [K];
  logic [DATA_W-1:0]      col_m   [K];
  logic [DATA_W-1:0]      col_new [K];
  logic [K*K*DATA_W-1:0]  win_next;

  assign in_ready = !rst && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Raster position of the pixel currently offered on in_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_W'(IMG_W - 1)) begin
        col <= '0;
        row <= (row == ROW_W'(IMG_H - 1)) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  row_delay #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_rd0 (
    .clk  (clk),
    .rst  (rst),
    .en   (accept),
    .din  (in_data),
    .dout (rd0_out)
  );

  row_delay #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_rd1 (
    .clk  (clk),
    .rst  (rst),
    .en   (accept),
    .din  (rd0_out),
    .dout (rd1_out)
  );

  // With stride 2 the valid anchors are the even rows/columns.
  always_comb begin
    stride_ok = 1'b1;
    if (STRIDE == 2)
      stride_ok = !row[0] && !col[0];
  end

  assign emit_pos = (row >= ROW_W'(2)) && (col >= COL_W'(2)) && stride_ok;
  assign last_pos = (row == ROW_W'(LAST_ROW)) && (col == COL_W'(LAST_COL));

  assign col_new[0] = rd1_out;
  assign col_new[1] = rd0_out;
  assign col_new[2] = in_data;

  always_comb begin
    win_next = '0;
    win_next[W_TL*DATA_W +: DATA_W] = col_l[0];
    win_next[W_TM*DATA_W +: DATA_W] = col_m[0];
    win_next[W_TR*DATA_W +: DATA_W] = col_new[0];
    win_next[W_ML*DATA_W +: DATA_W] = col_l[1];
    win_next[W_MM*DATA_W +: DATA_W] = col_m[1];
    win_next[W_MR*DATA_W +: DATA_W] = col_new[1];
    win_next[W_BL*DATA_W +: DATA_W] = col_l[2];
    win_next[W_BM*DATA_W +: DATA_W] = col_m[2];
    win_next[W_BR*DATA_W +: DATA_W] = col_new[2];
  end

  // Two older columns of the window; the newest column comes straight from the inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < K; i++) begin
        col_l[i] <= '0;
        col_m[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < K; i++) begin
        col_l[i] <= col_m[i];
        col_m[i] <= col_new[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      win       <= '0;
    end else if (accept) begin
      out_valid <= emit_pos;
      out_last  <= emit_pos && last_pos;
      if (emit_pos)
        win <= win_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: 5x4 stride-1 and 6x6 stride-2 instances.
module tb_conv_window_gen;
  localparam int DW = 9;
  localparam int WW = 9 * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
  logic [DW-1:0] a_in_data;
  logic [WW-1:0] a_win;
  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  logic [DW-1:0] b_in_data;
  logic [WW-1:0] b_win;

  conv_window_gen #(.DATA_W(DW), .IMG_W(5), .IMG_H(4), .STRIDE(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .win(a_win), .out_last(a_out_last)
  );

  conv_window_gen #(.DATA_W(DW), .IMG_W(6), .IMG_H(6), .STRIDE(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .win(b_win), .out_last(b_out_last)
  );

  typedef struct {
    logic [DW-1:0] pix;
    logic          emit;
    logic          last;
    logic [WW-1:0] exp_win;
  } vec_t;

  vec_t          tbl [20];
  logic [WW-1:0] first_win;
  int            checks = 0;
  int            errors = 0;

  function automatic logic [WW-1:0] model_win(input int base, input int w, input int r, input int c);
    logic [WW-1:0] v;
    v = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        v[(i*3+j)*DW +: DW] = DW'(base + (r - 2 + i) * w + (c - 2 + j));
    return v;
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0b want %0b", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // One 5x4 frame at full rate, every cycle compared against the table.
  task automatic apply_basic();
    int windows;
    windows = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a_in_valid  = 1'b1;
      a_in_data   = tbl[i].pix;
      a_out_ready = 1'b1;
      #1;
      check_bit($sformatf("in_ready_%0d", i), a_in_ready, 1'b1);
      @(posedge clk);
      #1;
      check_bit($sformatf("out_valid_%0d", i), a_out_valid, tbl[i].emit);
      if (tbl[i].emit) begin
        windows++;
        check_vec($sformatf("win_%0d", i), a_win, tbl[i].exp_win);
        check_bit($sformatf("out_last_%0d", i), a_out_last, tbl[i].last);
      end
      if (i == 12)
        check_vec("first_win", a_win, first_win);
    end
    check_int("basic_win_count", windows, 6);
    @(negedge clk);
    a_in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_bit("drain_valid", a_out_valid, 1'b0);
  endtask

  // Streams nframes 5x4 frames (frame f offset by 100*f) with optional input
  // gaps and a 5-cycle out_ready stall on window number bp_win.
  task automatic run_stream(input int nframes, input int gap_pct, input int bp_win);
    logic [WW-1:0] exp_q[$];
    logic          exp_l[$];
    logic [WW-1:0] held;
    int            sent, got, cyc, bp_left, total;
    bit            bp_done;
    for (int f = 0; f < nframes; f++)
      for (int r = 2; r < 4; r++)
        for (int c = 2; c < 5; c++) begin
          exp_q.push_back(model_win(100 * f, 5, r, c));
          exp_l.push_back(r == 3 && c == 4);
        end
    total = 20 * nframes;
    sent = 0; got = 0; cyc = 0; bp_left = 0; bp_done = 0; held = '0;
    while ((sent < total || got < exp_q.size()) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      a_in_valid = (sent < total) && ($urandom_range(99) >= gap_pct);
      a_in_data  = DW'(100 * (sent / 20) + (sent % 20));
      if (bp_win >= 0 && !bp_done && bp_left == 0 && a_out_valid && got == bp_win) begin
        bp_left = 5;
        held    = a_win;
      end
      a_out_ready = (bp_left == 0);
      #1;
      if (bp_left > 0) begin
        check_bit("bp_in_ready", a_in_ready, 1'b0);
        check_bit("bp_out_valid", a_out_valid, 1'b1);
        check_vec("bp_win_stable", a_win, held);
        bp_left--;
        if (bp_left == 0) bp_done = 1;
      end
      if (a_in_valid && a_in_ready) sent++;
      if (a_out_valid && a_out_ready) begin
        if (got < exp_q.size()) begin
          check_vec($sformatf("stream_win_%0d", got), a_win, exp_q[got]);
          check_bit($sformatf("stream_last_%0d", got), a_out_last, exp_l[got]);
        end else begin
          check_int("stream_extra_window", got, exp_q.size() - 1);
        end
        got++;
      end
    end
    @(negedge clk);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    check_int("stream_sent", sent, total);
    check_int("stream_got", got, exp_q.size());
    if (bp_win >= 0) check_bit("bp_happened", bp_done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int exp_b [4];
    int n;
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;

    for (int i = 0; i < 20; i++) begin
      tbl[i].pix     = DW'(i);
      tbl[i].emit    = (i / 5 >= 2) && (i % 5 >= 2);
      tbl[i].last    = (i == 19);
      tbl[i].exp_win = tbl[i].emit ? model_win(0, 5, i / 5, i % 5) : '0;
    end
    first_win = {9'd12, 9'd11, 9'd10, 9'd7, 9'd6, 9'd5, 9'd2, 9'd1, 9'd0};
    exp_b = '{14, 16, 26, 28};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_bit("rst_in_ready", a_in_ready, 1'b0);
    check_bit("rst_out_valid", a_out_valid, 1'b0);
    check_bit("rst_out_last", a_out_last, 1'b0);
    check_vec("rst_win", a_win, '0);
    check_bit("rst_b_out_valid", b_out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_bit("release_in_ready", a_in_ready, 1'b1);

    apply_basic();
    run_stream(1, 0, 2);
    run_stream(2, 30, -1);

    // Stride 2 on a 6x6 frame
    n = 0;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      b_in_valid  = 1'b1;
      b_in_data   = DW'(i);
      b_out_ready = 1'b1;
      @(posedge clk);
      #1;
      if (b_out_valid) begin
        if (n < 4) begin
          check_int($sformatf("stride_w8_%0d", n), int'(b_win[8*DW +: DW]), exp_b[n]);
          check_vec($sformatf("stride_win_%0d", n), b_win, model_win(0, 6, exp_b[n] / 6, exp_b[n] % 6));
          check_bit($sformatf("stride_last_%0d", n), b_out_last, n == 3);
        end
        n++;
      end
    end
    @(negedge clk);
    b_in_valid = 1'b0;
    check_int("stride_win_count", n, 4);

    // Reset in the middle of a frame
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      a_in_valid  = 1'b1;
      a_in_data   = DW'(50 + i);
      a_out_ready = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    a_in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_bit("midrst_in_ready", a_in_ready, 1'b0);
    @(posedge clk);
    #1;
    check_bit("midrst_out_valid", a_out_valid, 1'b0);
    check_bit("midrst_out_last", a_out_last, 1'b0);
    check_vec("midrst_win", a_win, '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_bit("midrst_release_in_ready", a_in_ready, 1'b1);
    apply_basic();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
